// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute/memory/write-back control sequencer
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        step,
    input  logic [3:0]  op_code,
    input  logic        zero,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        ir_load,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_write_en,
    output logic        wb_sel,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        busy,
    output logic        halted,
    output logic        bus_err,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERR
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;

    logic is_alu, is_load, is_store, is_beq, is_jump, is_halt, is_mem_op;
    logic retire, wait_expired;

    always_comb begin
        is_alu    = ~op_code[3];
        is_load   = (op_code == 4'h8);
        is_store  = (op_code == 4'h9);
        is_beq    = (op_code == 4'hA);
        is_jump   = (op_code == 4'hB);
        is_halt   = (op_code == 4'hF);
        is_mem_op = is_load | is_store;
    end

    assign wait_expired = (wait_cnt == 8'(MEM_TIMEOUT));

    // An instruction retires in the cycle its last enable is issued.
    assign retire = ((state == S_EXEC) && !is_mem_op) ||
                    ((state == S_MEM) && dmem_ack && is_store) ||
                    (state == S_WB);

    always_comb begin
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        reg_write_en = 1'b0;
        wb_sel       = 1'b0;
        pc_en        = 1'b0;
        pc_sel       = 2'b00;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            S_EXEC: begin
                if (is_alu) begin
                    reg_write_en = 1'b1;
                    pc_en        = 1'b1;
                end else if (is_beq) begin
                    pc_en  = 1'b1;
                    pc_sel = zero ? 2'b01 : 2'b00;
                end else if (is_jump) begin
                    pc_en  = 1'b1;
                    pc_sel = 2'b10;
                end else if (!is_mem_op && !is_halt) begin
                    pc_en = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                pc_en    = dmem_ack & is_store;
            end
            S_WB: begin
                reg_write_en = 1'b1;
                wb_sel       = 1'b1;
                pc_en        = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) ||
                     (state == S_MEM)   || (state == S_WB);
    assign halted  = (state == S_HALT);
    assign bus_err = (state == S_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= 8'd0;
            instr_count <= 16'd0;
        end else begin
            if (retire) begin
                instr_count <= instr_count + 16'd1;
            end
            case (state)
                S_IDLE: begin
                    if (run || step) begin
                        state    <= S_FETCH;
                        wait_cnt <= 8'd0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        state <= S_DECODE;
                    end else if (wait_expired) begin
                        state <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    if (is_mem_op) begin
                        state    <= S_MEM;
                        wait_cnt <= 8'd0;
                    end else if (is_halt) begin
                        state <= S_HALT;
                    end else if (run) begin
                        state    <= S_FETCH;
                        wait_cnt <= 8'd0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (is_load) begin
                            state <= S_WB;
                        end else if (run) begin
                            state    <= S_FETCH;
                            wait_cnt <= 8'd0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (wait_expired) begin
                        state <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WB: begin
                    if (run) begin
                        state    <= S_FETCH;
                        wait_cnt <= 8'd0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HALT:  state <= S_HALT;
                S_ERR:   state <= S_ERR;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, step, zero, imem_ack, dmem_ack;
    logic [3:0]  op_code;
    logic        imem_req, ir_load, dmem_req, dmem_we, reg_write_en, wb_sel, pc_en;
    logic [1:0]  pc_sel;
    logic        busy, halted, bus_err;
    logic [15:0] instr_count;

    cpu_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .op_code(op_code), .zero(zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_load(ir_load),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write_en(reg_write_en), .wb_sel(wb_sel),
        .pc_en(pc_en), .pc_sel(pc_sel), .busy(busy), .halted(halted), .bus_err(bus_err),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        imem_req, ir_load, dmem_req, dmem_we, reg_write_en, wb_sel, pc_en;
        logic [1:0]  pc_sel;
        logic        busy, halted, bus_err;
        logic [15:0] count;
    } exp_t;

    exp_t        exp_q[$];
    int          tag_q[$];
    int          tag = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic [15:0] exp_count;
    bit          step_in_decode = 1'b0;

    function automatic exp_t actual();
        exp_t a;
        a = {imem_req, ir_load, dmem_req, dmem_we, reg_write_en, wb_sel, pc_en,
             pc_sel, busy, halted, bus_err, instr_count};
        return a;
    endfunction

    // Expected outputs are queued per cycle by the driver and checked mid-cycle.
    always @(negedge clk) begin
        exp_t e, a;
        int   t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = actual();
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("FAIL cycle_check instr %0d: actual %h required %h", t, a, e);
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input exp_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t busy_vec();
        exp_t e = '0;
        e.busy  = 1'b1;
        e.count = exp_count;
        return e;
    endfunction

    task automatic idle_cycle(input logic r, input logic s);
        exp_t e = '0;
        run = r;
        step = s;
        e.count = exp_count;
        push(e);
        step = 1'b0;
    endtask

    task automatic halt_cycle();
        exp_t e = '0;
        e.halted = 1'b1;
        e.count  = exp_count;
        push(e);
    endtask

    task automatic err_cycle();
        exp_t e = '0;
        e.bus_err = 1'b1;
        e.count   = exp_count;
        push(e);
    endtask

    task automatic fetch_part(input int iw);
        exp_t e;
        imem_ack = 1'b0;
        for (int i = 0; i < iw; i++) begin
            e = busy_vec(); e.imem_req = 1'b1; push(e);
        end
        imem_ack = 1'b1;
        e = busy_vec(); e.imem_req = 1'b1; e.ir_load = 1'b1; push(e);
        imem_ack = 1'b0;
    endtask

    // One whole instruction starting in FETCH: iw imem waits, dw dmem waits.
    task automatic do_instr(input logic [3:0] op, input logic z, input int iw, input int dw);
        exp_t e;
        tag++;
        op_code = op;
        zero = z;
        fetch_part(iw);
        step = step_in_decode;
        push(busy_vec());
        step = 1'b0;
        e = busy_vec();
        if (op < 4'h8) begin
            e.reg_write_en = 1'b1; e.pc_en = 1'b1; push(e); exp_count++;
        end else if (op == 4'h8 || op == 4'h9) begin
            push(e);
            dmem_ack = 1'b0;
            for (int i = 0; i < dw; i++) begin
                e = busy_vec(); e.dmem_req = 1'b1; e.dmem_we = (op == 4'h9); push(e);
            end
            dmem_ack = 1'b1;
            e = busy_vec(); e.dmem_req = 1'b1; e.dmem_we = (op == 4'h9); e.pc_en = (op == 4'h9);
            push(e);
            dmem_ack = 1'b0;
            if (op == 4'h9) begin
                exp_count++;
            end else begin
                e = busy_vec(); e.reg_write_en = 1'b1; e.wb_sel = 1'b1; e.pc_en = 1'b1;
                push(e);
                exp_count++;
            end
        end else if (op == 4'hA) begin
            e.pc_en = 1'b1; e.pc_sel = z ? 2'b01 : 2'b00; push(e); exp_count++;
        end else if (op == 4'hB) begin
            e.pc_en = 1'b1; e.pc_sel = 2'b10; push(e); exp_count++;
        end else if (op == 4'hF) begin
            push(e); exp_count++;
        end else begin
            e.pc_en = 1'b1; push(e); exp_count++;
        end
    endtask

    task automatic apply_reset();
        #2;
        rst = 1'b1;
        #1;
        check_lit("async_reset_outputs", 32'(actual()), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_count = 16'd0;
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; run = 1'b0; step = 1'b0; zero = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; op_code = 4'h0;
        exp_count = 16'd0;
        #3;
        check_lit("reset_outputs", 32'(actual()), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Free-run ALU stream, then one of each class with assorted waits.
        idle_cycle(1'b1, 1'b0);
        do_instr(4'h3, 1'b0, 0, 0);
        check_lit("count_after_first_alu", 32'(instr_count), 32'd1);
        repeat (9) do_instr(4'h3, 1'b0, 0, 0);
        check_lit("count_after_ten_alu", 32'(instr_count), 32'd10);
        do_instr(4'h8, 1'b0, 0, 2);
        do_instr(4'h9, 1'b0, 0, 0);
        do_instr(4'hA, 1'b1, 0, 0);
        do_instr(4'hA, 1'b0, 0, 0);
        do_instr(4'hB, 1'b0, 0, 0);
        do_instr(4'hC, 1'b1, 0, 0);
        do_instr(4'hE, 1'b0, 0, 0);
        do_instr(4'h7, 1'b1, 2, 0);
        check_lit("count_after_mix", 32'(instr_count), 32'd18);

        // Dropping run lets the current instruction finish, then idles.
        run = 1'b0;
        do_instr(4'hD, 1'b0, 0, 0);
        idle_cycle(1'b0, 1'b0);
        idle_cycle(1'b0, 1'b0);
        check_lit("idle_not_busy", 32'(busy), 32'd0);

        // Single step with a stray step pulse during DECODE.
        idle_cycle(1'b0, 1'b1);
        step_in_decode = 1'b1;
        do_instr(4'h5, 1'b0, 1, 0);
        step_in_decode = 1'b0;
        idle_cycle(1'b0, 1'b0);
        idle_cycle(1'b0, 1'b0);
        check_lit("count_after_step", 32'(instr_count), 32'd20);

        // Acks arriving on the cycle the wait counter hits the limit.
        idle_cycle(1'b0, 1'b1);
        do_instr(4'h1, 1'b0, 15, 0);
        idle_cycle(1'b0, 1'b0);
        idle_cycle(1'b0, 1'b1);
        do_instr(4'h8, 1'b0, 0, 15);
        idle_cycle(1'b0, 1'b0);
        check_lit("no_error_at_limit", 32'(bus_err), 32'd0);

        // HALT retires without advancing the PC and holds until reset.
        idle_cycle(1'b1, 1'b0);
        do_instr(4'hF, 1'b0, 0, 0);
        step = 1'b1;
        halt_cycle();
        step = 1'b0;
        halt_cycle();
        halt_cycle();
        check_lit("halted_flag", 32'(halted), 32'd1);
        check_lit("count_after_halt", 32'(instr_count), 32'd23);
        apply_reset();

        // Reset in the middle of a LOAD memory wait.
        idle_cycle(1'b1, 1'b0);
        do_instr(4'h2, 1'b0, 0, 0);
        tag++;
        op_code = 4'h8;
        fetch_part(0);
        push(busy_vec());
        push(busy_vec());
        dmem_ack = 1'b0;
        e = busy_vec(); e.dmem_req = 1'b1; push(e);
        check_lit("dmem_req_before_rst", 32'(dmem_req), 32'd1);
        check_lit("count_before_rst", 32'(instr_count), 32'd1);
        apply_reset();
        check_lit("count_after_rst", 32'(instr_count), 32'd0);

        // Instruction fetch never acknowledged: ERR after 16 FETCH cycles.
        idle_cycle(1'b1, 1'b0);
        tag++;
        imem_ack = 1'b0;
        repeat (16) begin
            e = busy_vec(); e.imem_req = 1'b1; push(e);
        end
        imem_ack = 1'b1;
        repeat (3) err_cycle();
        imem_ack = 1'b0;
        check_lit("bus_err_flag", 32'(bus_err), 32'd1);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
